// File: rtl/axi4_lite_globals_pkg.sv
// Shared AXI4-Lite definitions: bus width defaults, response codes and the
// slave write-responder state encoding.
package Axi4LiteGlobalsPkg;

  localparam int AXI_ADDR_WIDTH = 32;
  localparam int AXI_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_t;

  typedef enum logic [2:0] {
    WR_IDLE    = 3'd0,
    WR_HAVE_AW = 3'd1,
    WR_HAVE_W  = 3'd2,
    WR_COMMIT  = 3'd3,
    WR_RESP    = 3'd4
  } wr_state_t;

endpackage

// File: rtl/axi4_lite_reg_bank.sv
// NUM_REGS x DATA_WIDTH register storage with a byte-strobed write port,
// asynchronous active-high clear and a combinational read port.
module axi4_lite_reg_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        we,
  input  logic [$clog2(NUM_REGS)-1:0] widx,
  input  logic [DATA_WIDTH-1:0]       wdata,
  input  logic [DATA_WIDTH/8-1:0]     wstrb,
  input  logic [$clog2(NUM_REGS)-1:0] rindex,
  output logic [DATA_WIDTH-1:0]       rdata
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  // Byte-lane merge of the write data into the addressed register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
    end else if (we) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (wstrb[b]) regs[widx][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  // Peek port: plain combinational read of the selected register.
  always_comb begin
    rdata = regs[rindex];
  end

endmodule

// File: rtl/axi4_lite_slave_write_responder.sv
// AXI4-Lite slave write engine: accepts AW and W independently, commits the
// strobe-masked write into a local register bank and returns a B response.
// Optional build macro: AXI4_LITE_SLAVE_WRITE_PROT_CHECK_EN rejects
// non-secure (awprot[1]=1) writes with SLVERR.
//
// Handshake rule: a transfer happens on a channel at a rising aclk edge where
// both its valid and ready are high. Readies are registered and only offered
// for a channel that is not already held; bvalid, once raised, holds with a
// stable bresp until the edge where bready is also high.
module axi4_lite_slave_write_responder
  import Axi4LiteGlobalsPkg::*;
#(
  parameter int ADDRESS_WIDTH = AXI_ADDR_WIDTH,
  parameter int DATA_WIDTH    = AXI_DATA_WIDTH,
  parameter int NUM_REGS      = 16
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic [ADDRESS_WIDTH-1:0]    awaddr,
  input  logic [2:0]                  awprot,
  input  logic                        awvalid,
  output logic                        awready,
  input  logic [DATA_WIDTH-1:0]       wdata,
  input  logic [DATA_WIDTH/8-1:0]     wstrb,
  input  logic                        wvalid,
  output logic                        wready,
  output logic [1:0]                  bresp,
  output logic                        bvalid,
  input  logic                        bready,
  input  logic [$clog2(NUM_REGS)-1:0] rd_index,
  output logic [DATA_WIDTH-1:0]       rd_data,
  output logic [2:0]                  dbg_state
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int IDX_WIDTH  = $clog2(NUM_REGS);
  localparam int ADDR_LSB   = $clog2(STRB_WIDTH);

  wr_state_t                state_q, state_d;
  logic                     aw_held_q, aw_held_d;
  logic                     w_held_q, w_held_d;
  logic [ADDRESS_WIDTH-1:0] awaddr_q;
  logic [2:0]               awprot_q;
  logic [DATA_WIDTH-1:0]    wdata_q;
  logic [STRB_WIDTH-1:0]    wstrb_q;
  axi_resp_t                bresp_q, bresp_d;
  logic                     awready_d, wready_d, bvalid_d;
  logic                     aw_hs, w_hs;
  logic                     in_range, access_ok, commit_we;
  logic [IDX_WIDTH-1:0]     commit_idx;

  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid & wready;

  // Address decode of the held write: word index plus an all-zero upper field.
  assign commit_idx = awaddr_q[ADDR_LSB +: IDX_WIDTH];
  assign in_range   = ((awaddr_q >> (ADDR_LSB + IDX_WIDTH)) == '0);

`ifdef AXI4_LITE_SLAVE_WRITE_PROT_CHECK_EN
  assign access_ok = in_range & ~awprot_q[1];
`else
  logic unused_awprot;
  assign unused_awprot = ^awprot_q;
  assign access_ok     = in_range;
`endif

  assign commit_we = (state_q == WR_COMMIT) & access_ok;

  // Next state, held-channel flags, registered readies and response.
  always_comb begin
    state_d   = state_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    bresp_d   = bresp_q;
    // The FSM advances on held flags, so a handshake shows up in the state
    // one edge later; the flags themselves gate the readies immediately.
    unique case (state_q)
      WR_IDLE: begin
        if (aw_held_q && w_held_q) state_d = WR_COMMIT;
        else if (aw_held_q)        state_d = WR_HAVE_AW;
        else if (w_held_q)         state_d = WR_HAVE_W;
      end
      WR_HAVE_AW: if (w_held_q)  state_d = WR_COMMIT;
      WR_HAVE_W:  if (aw_held_q) state_d = WR_COMMIT;
      WR_COMMIT: begin
        state_d = WR_RESP;
        bresp_d = access_ok ? RESP_OKAY : RESP_SLVERR;
      end
      WR_RESP:    if (bready) state_d = WR_IDLE;
      default:    state_d = WR_IDLE;
    endcase
    if (state_q == WR_COMMIT) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
    end else begin
      if (aw_hs) aw_held_d = 1'b1;
      if (w_hs)  w_held_d  = 1'b1;
    end
    awready_d = ((state_d == WR_IDLE) || (state_d == WR_HAVE_W)) && !aw_held_d;
    wready_d  = ((state_d == WR_IDLE) || (state_d == WR_HAVE_AW)) && !w_held_d;
    bvalid_d  = (state_d == WR_RESP);
  end

  // State, handshake flags and bus-facing outputs.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q   <= WR_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awready   <= 1'b0;
      wready    <= 1'b0;
      bvalid    <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      state_q   <= state_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awready   <= awready_d;
      wready    <= wready_d;
      bvalid    <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

  // Holding registers capture each channel's payload at its handshake.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      awaddr_q <= '0;
      awprot_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
    end else begin
      if (aw_hs) begin
        awaddr_q <= awaddr;
        awprot_q <= awprot;
      end
      if (w_hs) begin
        wdata_q <= wdata;
        wstrb_q <= wstrb;
      end
    end
  end

  assign bresp     = bresp_q;
  assign dbg_state = state_q;

  axi4_lite_reg_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS)
  ) u_reg_bank (
    .clk    (aclk),
    .rst    (areset),
    .we     (commit_we),
    .widx   (commit_idx),
    .wdata  (wdata_q),
    .wstrb  (wstrb_q),
    .rindex (rd_index),
    .rdata  (rd_data)
  );

endmodule

// File: tb/tb_axi4_lite_slave_write_responder.sv
// Directed bench for axi4_lite_slave_write_responder (default parameters).
module tb_axi4_lite_slave_write_responder;
  import Axi4LiteGlobalsPkg::*;

  logic        aclk;
  logic        areset;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid, wready;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic [3:0]  rd_index;
  logic [31:0] rd_data;
  logic [2:0]  dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_regs [16];

  axi4_lite_slave_write_responder dut (
    .aclk(aclk), .areset(areset), .awaddr(awaddr), .awprot(awprot),
    .awvalid(awvalid), .awready(awready), .wdata(wdata), .wstrb(wstrb),
    .wvalid(wvalid), .wready(wready), .bresp(bresp), .bvalid(bvalid),
    .bready(bready), .rd_index(rd_index), .rd_data(rd_data), .dbg_state(dbg_state)
  );

  // Clock and reset
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  // Full write through both channels; returns the B response.
  task automatic do_write(input logic [31:0] addr, input logic [2:0] prot,
                          input logic [31:0] data, input logic [3:0] strb,
                          output logic [1:0] resp);
    logic aw_now, w_now, got;
    awaddr = addr; awprot = prot; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1;
    for (int c = 0; c < 20 && (awvalid || wvalid); c++) begin
      aw_now = awvalid & awready;
      w_now  = wvalid & wready;
      tick();
      if (aw_now) awvalid = 1'b0;
      if (w_now)  wvalid  = 1'b0;
    end
    if (awvalid || wvalid) begin
      n_cmp++; n_err++;
      $display("FAIL write_accept_timeout: addr %h still pending, expected acceptance", addr);
      awvalid = 1'b0; wvalid = 1'b0;
    end
    resp = 2'bxx; got = 1'b0; bready = 1'b1;
    for (int c = 0; c < 20 && !got; c++) begin
      if (bvalid) begin
        resp = bresp;
        got = 1'b1;
      end
      tick();
    end
    bready = 1'b0;
    if (!got) begin
      n_cmp++; n_err++;
      $display("FAIL bvalid_timeout: addr %h no response, expected bvalid", addr);
    end
  endtask

  task automatic check_all_regs(input string tag);
    for (int i = 0; i < 16; i++) begin
      rd_index = i[3:0];
      #1;
      n_cmp++;
      if (rd_data !== exp_regs[i]) begin
        n_err++;
        $display("FAIL %s_reg%0d: got %h expected %h", tag, i, rd_data, exp_regs[i]);
      end
    end
  endtask

  task automatic test_reset;
    areset = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    areset = 1'b0;
    rd_index = 4'd0;
    #1;
    n_cmp++; if (awready !== 1'b0) begin n_err++; $display("FAIL reset_awready: got %b expected 0", awready); end
    n_cmp++; if (wready !== 1'b0) begin n_err++; $display("FAIL reset_wready: got %b expected 0", wready); end
    n_cmp++; if (bvalid !== 1'b0) begin n_err++; $display("FAIL reset_bvalid: got %b expected 0", bvalid); end
    n_cmp++; if (bresp !== 2'b00) begin n_err++; $display("FAIL reset_bresp: got %b expected 00", bresp); end
    n_cmp++; if (dbg_state !== WR_IDLE) begin n_err++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
    n_cmp++; if (rd_data !== 32'h0) begin n_err++; $display("FAIL reset_reg0: got %h expected 0", rd_data); end
    tick();
    n_cmp++; if (awready !== 1'b1) begin n_err++; $display("FAIL reset_awready_rise: got %b expected 1", awready); end
    n_cmp++; if (wready !== 1'b1) begin n_err++; $display("FAIL reset_wready_rise: got %b expected 1", wready); end
  endtask

  task automatic test_same_cycle;
    rd_index = 4'd2;
    awaddr = 32'h08; awprot = 3'b000; wdata = 32'hDEADBEEF; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    n_cmp++; if (awready !== 1'b0) begin n_err++; $display("FAIL same_awready_drop: got %b expected 0", awready); end
    n_cmp++; if (wready !== 1'b0) begin n_err++; $display("FAIL same_wready_drop: got %b expected 0", wready); end
    tick();
    n_cmp++; if (dbg_state !== WR_COMMIT) begin n_err++; $display("FAIL same_commit_state: got %0d expected 3", dbg_state); end
    n_cmp++; if (bvalid !== 1'b0) begin n_err++; $display("FAIL same_bvalid_early: got %b expected 0", bvalid); end
    tick();
    n_cmp++; if (bvalid !== 1'b1) begin n_err++; $display("FAIL same_bvalid: got %b expected 1", bvalid); end
    n_cmp++; if (bresp !== 2'b00) begin n_err++; $display("FAIL same_bresp: got %b expected 00", bresp); end
    n_cmp++; if (rd_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL same_reg2: got %h expected deadbeef", rd_data); end
    exp_regs[2] = 32'hDEADBEEF;
    bready = 1'b1;
    tick();
    bready = 1'b0;
    n_cmp++; if (bvalid !== 1'b0) begin n_err++; $display("FAIL same_bvalid_clear: got %b expected 0", bvalid); end
    n_cmp++; if (awready !== 1'b1 || wready !== 1'b1) begin n_err++; $display("FAIL same_ready_return: got %b%b expected 11", awready, wready); end
  endtask

  task automatic test_w_first;
    rd_index = 4'd3;
    wdata = 32'h12345678; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    n_cmp++; if (wready !== 1'b0) begin n_err++; $display("FAIL wfirst_wready: got %b expected 0", wready); end
    n_cmp++; if (awready !== 1'b1) begin n_err++; $display("FAIL wfirst_awready: got %b expected 1", awready); end
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++;
      if (bvalid !== 1'b0 || rd_data !== 32'h0 || awready !== 1'b1) begin
        n_err++;
        $display("FAIL wfirst_wait%0d: got bvalid %b reg3 %h awready %b expected 0 0 1", c, bvalid, rd_data, awready);
      end
    end
    awaddr = 32'h0C; awprot = 3'b000; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    tick();
    n_cmp++; if (bvalid !== 1'b0) begin n_err++; $display("FAIL wfirst_bvalid_early: got %b expected 0", bvalid); end
    tick();
    n_cmp++; if (bvalid !== 1'b1) begin n_err++; $display("FAIL wfirst_bvalid: got %b expected 1", bvalid); end
    n_cmp++; if (bresp !== 2'b00) begin n_err++; $display("FAIL wfirst_bresp: got %b expected 00", bresp); end
    n_cmp++; if (rd_data !== 32'h12345678) begin n_err++; $display("FAIL wfirst_reg3: got %h expected 12345678", rd_data); end
    exp_regs[3] = 32'h12345678;
    bready = 1'b1;
    tick();
    bready = 1'b0;
  endtask

  task automatic test_strobe;
    logic [1:0] r;
    do_write(32'h04, 3'b000, 32'hFFFFFFFF, 4'hF, r);
    do_write(32'h04, 3'b000, 32'h00001234, 4'h3, r);
    n_cmp++; if (r !== 2'b00) begin n_err++; $display("FAIL strobe_bresp: got %b expected 00", r); end
    rd_index = 4'd1;
    #1;
    n_cmp++; if (rd_data !== 32'hFFFF1234) begin n_err++; $display("FAIL strobe_reg1: got %h expected ffff1234", rd_data); end
    exp_regs[1] = 32'hFFFF1234;
  endtask

  task automatic test_out_of_range;
    logic [1:0] r;
    do_write(32'h40, 3'b000, 32'hAAAAAAAA, 4'hF, r);
    n_cmp++; if (r !== 2'b10) begin n_err++; $display("FAIL oor_bresp: got %b expected 10", r); end
    check_all_regs("oor");
  endtask

  task automatic test_prot;
    logic [1:0] r;
    do_write(32'h00, 3'b010, 32'hCAFEF00D, 4'hF, r);
`ifdef AXI4_LITE_SLAVE_WRITE_PROT_CHECK_EN
    n_cmp++; if (r !== 2'b10) begin n_err++; $display("FAIL prot_bresp: got %b expected 10", r); end
`else
    n_cmp++; if (r !== 2'b00) begin n_err++; $display("FAIL prot_bresp: got %b expected 00", r); end
    exp_regs[0] = 32'hCAFEF00D;
`endif
    check_all_regs("prot");
  endtask

  task automatic test_backpressure;
    rd_index = 4'd6;
    awaddr = 32'h14; awprot = 3'b000; wdata = 32'h55AA55AA; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    tick();
    tick();
    exp_regs[5] = 32'h55AA55AA;
    awaddr = 32'h18; awvalid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      n_cmp++;
      if (bvalid !== 1'b1 || bresp !== 2'b00 || awready !== 1'b0 || wready !== 1'b0) begin
        n_err++;
        $display("FAIL bp_hold%0d: got bvalid %b bresp %b awready %b wready %b expected 1 00 0 0",
                 c, bvalid, bresp, awready, wready);
      end
      tick();
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    n_cmp++; if (bvalid !== 1'b0) begin n_err++; $display("FAIL bp_bvalid_clear: got %b expected 0", bvalid); end
    n_cmp++; if (awready !== 1'b1) begin n_err++; $display("FAIL bp_awready_after: got %b expected 1", awready); end
    tick();
    awvalid = 1'b0;
    n_cmp++; if (awready !== 1'b0) begin n_err++; $display("FAIL bp_aw_accepted: got awready %b expected 0", awready); end
    wdata = 32'h0F0F0F0F; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    tick();
    n_cmp++; if (bvalid !== 1'b0) begin n_err++; $display("FAIL bp2_bvalid_early: got %b expected 0", bvalid); end
    tick();
    n_cmp++; if (bvalid !== 1'b1 || bresp !== 2'b00) begin n_err++; $display("FAIL bp2_resp: got %b %b expected 1 00", bvalid, bresp); end
    n_cmp++; if (rd_data !== 32'h0F0F0F0F) begin n_err++; $display("FAIL bp2_reg6: got %h expected 0f0f0f0f", rd_data); end
    exp_regs[6] = 32'h0F0F0F0F;
    bready = 1'b1;
    tick();
    bready = 1'b0;
    check_all_regs("bp");
  endtask

  task automatic test_reset_in_resp;
    logic [1:0] r;
    awaddr = 32'h1C; awprot = 3'b000; wdata = 32'h11111111; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    tick();
    tick();
    n_cmp++; if (bvalid !== 1'b1) begin n_err++; $display("FAIL rst_pre_bvalid: got %b expected 1", bvalid); end
    #2;
    areset = 1'b1;
    #1;
    n_cmp++; if (bvalid !== 1'b0) begin n_err++; $display("FAIL rst_async_bvalid: got %b expected 0", bvalid); end
    n_cmp++; if (awready !== 1'b0 || wready !== 1'b0) begin n_err++; $display("FAIL rst_async_ready: got %b%b expected 00", awready, wready); end
    for (int i = 0; i < 16; i++) exp_regs[i] = 32'h0;
    check_all_regs("rst");
    tick();
    areset = 1'b0;
    #1;
    n_cmp++; if (awready !== 1'b0 || wready !== 1'b0) begin n_err++; $display("FAIL rst_release_ready: got %b%b expected 00", awready, wready); end
    tick();
    n_cmp++; if (awready !== 1'b1 || wready !== 1'b1) begin n_err++; $display("FAIL rst_ready_rise: got %b%b expected 11", awready, wready); end
    do_write(32'h08, 3'b000, 32'h0BADCAFE, 4'hF, r);
    n_cmp++; if (r !== 2'b00) begin n_err++; $display("FAIL rst_new_bresp: got %b expected 00", r); end
    exp_regs[2] = 32'h0BADCAFE;
    check_all_regs("rst_new");
  endtask

  initial begin
    areset = 1'b1; awaddr = '0; awprot = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0; rd_index = '0;
    for (int i = 0; i < 16; i++) exp_regs[i] = 32'h0;
    test_reset();
    test_same_cycle();
    test_w_first();
    test_strobe();
    test_out_of_range();
    test_prot();
    test_backpressure();
    test_reset_in_resp();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axi4_lite_slave_write_responder.md
# axi4_lite_slave_write_responder

Slave-side write-transaction engine for the AXI4-Lite slave agent. It consumes the AW, W and B signals carried by the slave write interface, commits each accepted write into a local strobe-masked register bank, and returns a write response. It closes the pin-level write path so the verification environment has a real responding slave.

## Interface
- ADDRESS_WIDTH, 32: awaddr width.
- DATA_WIDTH, 32: wdata width, 32 or 64; strobe width is DATA_WIDTH/8.
- NUM_REGS, 16: register count, a power of 2 no greater than 2^(ADDRESS_WIDTH-log2(DATA_WIDTH/8)).

Ports:
- aclk, input, 1: clock; all logic is on the rising edge.
- areset, input, 1: asynchronous, active-high reset.
- awaddr, input, ADDRESS_WIDTH: write address (byte address).
- awprot, input, 3: protection attributes.
- awvalid / awready, input / output, 1: AW handshake.
- wdata, input, DATA_WIDTH: write data.
- wstrb, input, DATA_WIDTH/8: byte lane strobes.
- wvalid / wready, input / output, 1: W handshake.
- bresp, output, 2: response code (00 OKAY, 10 SLVERR).
- bvalid / bready, output / input, 1: B handshake.
- rd_index, input, log2(NUM_REGS): peek index.
- rd_data, output, DATA_WIDTH: combinational value of regs[rd_index].

## Operation
- Register index is awaddr[log2(DATA_WIDTH/8) +: log2(NUM_REGS)]. The low byte-offset bits are ignored.
- A write is in range when the remaining upper address bits are zero. Out-of-range writes return SLVERR and modify nothing.
- States:
  - IDLE: waiting for AW and W.
  - HAVE_AW: address captured, waiting for W.
  - HAVE_W: data captured, waiting for AW.
  - COMMIT: both captured.
  - RESP: response presented.
- AW and W are accepted independently, in either order, and in the same cycle if both arrive together.
- A handshake (valid & ready at an edge) captures the payload into holding registers.
- When both are held, the state goes to COMMIT.
- COMMIT to RESP (one cycle):
  - For each byte lane i with wstrb[i]=1, regs[idx] byte i is loaded with wdata byte i.
  - Lanes with wstrb[i]=0 keep their old value.
  - bresp and bvalid are registered.
- RESP holds until bvalid & bready, then returns to IDLE.
- Only one outstanding transaction is allowed; no write interleaving.

## Timing
- Reset values: awready=0, wready=0, bvalid=0, bresp=00, all regs=0, state=IDLE, holding registers cleared.
- awready is registered and equals 1 only in IDLE or HAVE_W. wready equals 1 only in IDLE or HAVE_AW. Both are 0 in the first cycle after reset deassertion and 1 from the next cycle.
- When the second handshake happens at edge N:
  - edge N+1: enter COMMIT;
  - edge N+2: regs are updated, bvalid=1 and bresp is valid.
- Minimum AW/W handshake to bvalid is therefore 2 cycles.
- bvalid and bresp stay stable while bready=0.
- After the B handshake at edge M, awready and wready are 1 from edge M+1.
- Simultaneous AW and W handshakes move directly from IDLE to COMMIT.
- Duplicate valid on an already-captured channel is ignored, because its ready is low.
- areset asserted in any state clears all outputs and regs immediately (asynchronous). An in-flight transaction is dropped with no response.
- rd_data reflects a commit in the cycle after the committing edge.

## Configuration
- AXI4_LITE_SLAVE_WRITE_PROT_CHECK_EN defined: a write with awprot[1]=1 (non-secure) returns SLVERR and writes nothing, even when in range.
- Undefined: awprot is ignored, and in-range writes always return OKAY.

## Structure
- Axi4LiteGlobalsPkg gets:
  - the response enum (OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11);
  - the write-responder state enum.
- ADDRESS_WIDTH and DATA_WIDTH defaults come from that package.
- The FSM and handshakes live in the top module.
- Sub-module axi4_lite_reg_bank: NUM_REGS x DATA_WIDTH storage with a byte-strobe write port, asynchronous reset, and a combinational read port.

## Test plan
- AW+W in the same cycle, awaddr=0x08, wdata=0xDEADBEEF, wstrb=0xF → regs[2]=0xDEADBEEF; bvalid 2 cycles later with bresp=00.
- W handshake 3 cycles before AW, awaddr=0x0C, wdata=0x12345678:
  - wready=0 after the W handshake while awready=1;
  - write commits only after AW;
  - regs[3]=0x12345678, bresp=00.
- regs[1]=0xFFFFFFFF, write awaddr=0x04, wdata=0x00001234, wstrb=0x3 → regs[1]=0xFFFF1234, bresp=00.
- awaddr=0x40 with NUM_REGS=16 → bresp=10 and all regs unchanged. With the macro defined, awaddr=0x00 and awprot=3'b010 → bresp=10 and regs[0] unchanged.
- bready held 0 for 5 cycles in RESP:
  - bvalid=1 and bresp stable throughout;
  - awready=wready=0;
  - new awvalid is not accepted until 1 cycle after the B handshake.
- areset pulsed while in RESP → bvalid, awready, wready and every regs entry go to 0 without waiting for a clock edge. After release, readies rise and a new write completes normally.
